// File: rtl/bscan_bridge_pkg.sv
// Shared types and constants for the JTAG scan-stage command bridge.
package bscan_bridge_pkg;

  // Header opcode field, bits [31:30] of a command word
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } opcode_t;

  // Bridge transaction states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_RESP
  } state_t;

  // Read data returned to the scan stage when the bus never answers
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/bscan_cmd_bridge.sv
// Bridge between a JTAG scan-stage command stream and a register bus.
// A header word selects READ/WRITE; WRITE takes one extra data word.
// Bus completions are bounded by a timeout; READs return one response word.
module bscan_cmd_bridge
  import bscan_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  fromBscan_enq__ENA,
  input  logic [31:0]           fromBscan_enq_v,
  output logic                  fromBscan_enq__RDY,
  output logic                  toBscan_enq__ENA,
  output logic [31:0]           toBscan_enq_v,
  input  logic                  toBscan_enq__RDY,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_req_write,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [31:0]           bus_req_wdata,
  input  logic                  bus_rsp_valid,
  input  logic [31:0]           bus_rsp_rdata,
  output logic [7:0]            err_count
);

  // Last BUS_WAIT cycle index before the transaction is abandoned
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  write_q;
  logic [15:0]           tcnt_q;
  logic [7:0]            err_q;

  opcode_t hdr_op;
  logic    cmd_fire;
  logic    hdr_take;
  logic    wdata_take;
  logic    req_fire;
  logic    rsp_take;
  logic    timeout_hit;
  logic    err_inc;

  assign hdr_op   = opcode_t'(fromBscan_enq_v[31:30]);
  // Ready is gated by reset so the scan stage sees a stalled bridge while RST is high
  assign fromBscan_enq__RDY = !RST && (state_q == ST_IDLE || state_q == ST_WDATA);
  assign cmd_fire = fromBscan_enq__ENA && fromBscan_enq__RDY;
  assign req_fire = (state_q == ST_BUS_REQ) && bus_req_ready;

  assign bus_req_valid    = (state_q == ST_BUS_REQ);
  assign bus_req_write    = write_q;
  assign bus_req_addr     = addr_q;
  assign bus_req_wdata    = wdata_q;
  assign toBscan_enq__ENA = (state_q == ST_RESP) && toBscan_enq__RDY;
  assign toBscan_enq_v    = rdata_q;
  assign err_count        = err_q;

  // Next-state decode and per-cycle capture strobes
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    hdr_take    = 1'b0;
    wdata_take  = 1'b0;
    rsp_take    = 1'b0;
    timeout_hit = 1'b0;
    err_inc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          unique case (hdr_op)
            OP_READ: begin
              hdr_take = 1'b1;
              state_d  = ST_BUS_REQ;
            end
            OP_WRITE: begin
              hdr_take = 1'b1;
              state_d  = ST_WDATA;
            end
            OP_RSVD: err_inc = 1'b1;
            default: ;
          endcase
        end
      end
      ST_WDATA: begin
        if (cmd_fire) begin
          wdata_take = 1'b1;
          state_d    = ST_BUS_REQ;
        end
      end
      ST_BUS_REQ: begin
        if (req_fire) state_d = ST_BUS_WAIT;
      end
      ST_BUS_WAIT: begin
        // A completion in the final allowed cycle beats the timeout
        if (bus_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = write_q ? ST_IDLE : ST_RESP;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          err_inc     = 1'b1;
          state_d     = write_q ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (toBscan_enq__RDY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and transaction latches
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      tcnt_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hdr_take) begin
        addr_q  <= fromBscan_enq_v[ADDR_WIDTH-1:0];
        write_q <= (hdr_op == OP_WRITE);
      end
      if (wdata_take) wdata_q <= fromBscan_enq_v;
      if (rsp_take) rdata_q <= bus_rsp_rdata;
      else if (timeout_hit) rdata_q <= TIMEOUT_DATA;
      if (req_fire) tcnt_q <= '0;
      else if (state_q == ST_BUS_WAIT) tcnt_q <= tcnt_q + 16'd1;
      if (err_inc) err_q <= sat_inc8(err_q);
    end
  end

endmodule

// File: tb/tb_bscan_cmd_bridge.sv
// Directed self-checking bench for bscan_cmd_bridge.
module tb_bscan_cmd_bridge;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fromBscan_enq__ENA = 1'b0;
  logic [31:0] fromBscan_enq_v = '0;
  logic        fromBscan_enq__RDY;
  logic        toBscan_enq__ENA;
  logic [31:0] toBscan_enq_v;
  logic        toBscan_enq__RDY = 1'b1;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b1;
  logic        bus_req_write;
  logic [15:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;
  logic [7:0]  err_count;

  int pass_count = 0;
  int total_count = 0;
  int ena_count = 0;
  int req_count = 0;

  bscan_cmd_bridge #(.ADDR_WIDTH(16), .TIMEOUT(255)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .fromBscan_enq__ENA (fromBscan_enq__ENA),
    .fromBscan_enq_v    (fromBscan_enq_v),
    .fromBscan_enq__RDY (fromBscan_enq__RDY),
    .toBscan_enq__ENA   (toBscan_enq__ENA),
    .toBscan_enq_v      (toBscan_enq_v),
    .toBscan_enq__RDY   (toBscan_enq__RDY),
    .bus_req_valid      (bus_req_valid),
    .bus_req_ready      (bus_req_ready),
    .bus_req_write      (bus_req_write),
    .bus_req_addr       (bus_req_addr),
    .bus_req_wdata      (bus_req_wdata),
    .bus_rsp_valid      (bus_rsp_valid),
    .bus_rsp_rdata      (bus_rsp_rdata),
    .err_count          (err_count)
  );

  always #5 CLK = ~CLK;

  // Handshake counters for "no activity" style checks
  always @(posedge CLK) begin
    if (toBscan_enq__ENA) ena_count++;
    if (bus_req_valid && bus_req_ready) req_count++;
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    fromBscan_enq__ENA = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_req_ready = 1'b1;
    toBscan_enq__RDY = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    total_count++;
    if ({fromBscan_enq__RDY, toBscan_enq__ENA, bus_req_valid} !== 3'b000) begin
      $display("FAIL reset_outputs: got rdy/ena/valid=%b required 000",
               {fromBscan_enq__RDY, toBscan_enq__ENA, bus_req_valid});
    end else pass_count++;
    total_count++;
    if (err_count !== 8'd0) $display("FAIL reset_err: got %0d required 0", err_count);
    else pass_count++;
    RST = 1'b0;
    @(negedge CLK);
    total_count++;
    if (fromBscan_enq__RDY !== 1'b1) $display("FAIL idle_rdy: got %b required 1", fromBscan_enq__RDY);
    else pass_count++;
  endtask

  task automatic test_read();
    int e0 = ena_count;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h4000_0010;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b0;
    total_count++;
    if ({bus_req_valid, bus_req_write, bus_req_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      $display("FAIL read_req: got valid=%b write=%b addr=%h required 1 0 0010",
               bus_req_valid, bus_req_write, bus_req_addr);
    end else pass_count++;
    @(negedge CLK);
    total_count++;
    if (bus_req_valid !== 1'b0 || toBscan_enq__ENA !== 1'b0) begin
      $display("FAIL read_wait: got valid=%b ena=%b required 0 0", bus_req_valid, toBscan_enq__ENA);
    end else pass_count++;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h1234_5678;
    @(negedge CLK);
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = 32'h0;
    total_count++;
    if (toBscan_enq__ENA !== 1'b1 || toBscan_enq_v !== 32'h1234_5678) begin
      $display("FAIL read_resp: got ena=%b data=%h required 1 12345678", toBscan_enq__ENA, toBscan_enq_v);
    end else pass_count++;
    @(negedge CLK);
    total_count++;
    if (ena_count - e0 != 1 || err_count !== 8'd0 || fromBscan_enq__RDY !== 1'b1) begin
      $display("FAIL read_done: got enas=%0d err=%0d rdy=%b required 1 0 1",
               ena_count - e0, err_count, fromBscan_enq__RDY);
    end else pass_count++;
  endtask

  task automatic test_write();
    int e0 = ena_count;
    int r0 = req_count;
    @(negedge CLK);
    bus_req_ready = 1'b0;
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h8000_0020;
    @(negedge CLK);
    fromBscan_enq_v = 32'hCAFE_F00D;
    total_count++;
    if (fromBscan_enq__RDY !== 1'b1) $display("FAIL wdata_rdy: got %b required 1", fromBscan_enq__RDY);
    else pass_count++;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b0;
    repeat (2) @(negedge CLK);
    total_count++;
    if ({bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata} !==
        {1'b1, 1'b1, 16'h0020, 32'hCAFE_F00D}) begin
      $display("FAIL write_req: got valid=%b write=%b addr=%h wdata=%h required 1 1 0020 cafef00d",
               bus_req_valid, bus_req_write, bus_req_addr, bus_req_wdata);
    end else pass_count++;
    bus_req_ready = 1'b1;
    @(negedge CLK);
    total_count++;
    if (bus_req_valid !== 1'b0 || req_count - r0 != 1) begin
      $display("FAIL write_handshake: got valid=%b reqs=%0d required 0 1", bus_req_valid, req_count - r0);
    end else pass_count++;
    bus_rsp_valid = 1'b1;
    @(negedge CLK);
    bus_rsp_valid = 1'b0;
    repeat (2) @(negedge CLK);
    total_count++;
    if (fromBscan_enq__RDY !== 1'b1 || ena_count != e0) begin
      $display("FAIL write_done: got rdy=%b enas=%0d required 1 0", fromBscan_enq__RDY, ena_count - e0);
    end else pass_count++;
  endtask

  task automatic test_timeout();
    int k;
    bit seen;
    logic [31:0] data;
    // No response at all: abort after 255 BUS_WAIT cycles
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h4000_0044;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b0;
    k = 1;
    seen = 1'b0;
    data = '0;
    while (!seen && k < 400) begin
      if (toBscan_enq__ENA) begin
        seen = 1'b1;
        data = toBscan_enq_v;
      end else begin
        @(negedge CLK);
        k++;
      end
    end
    total_count++;
    if (!seen || k != 257 || data !== 32'hDEAD_BEEF) begin
      $display("FAIL timeout_resp: got seen=%b cycle=%0d data=%h required 1 257 deadbeef", seen, k, data);
    end else pass_count++;
    @(negedge CLK);
    total_count++;
    if (err_count !== 8'd1) $display("FAIL timeout_err: got %0d required 1", err_count);
    else pass_count++;
    // Response lands in the final allowed cycle: real data wins
    do_reset();
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h4000_0048;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b0;
    repeat (255) @(negedge CLK);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hA5A5_0001;
    @(negedge CLK);
    bus_rsp_valid = 1'b0;
    total_count++;
    if (toBscan_enq__ENA !== 1'b1 || toBscan_enq_v !== 32'hA5A5_0001) begin
      $display("FAIL edge_resp: got ena=%b data=%h required 1 a5a50001", toBscan_enq__ENA, toBscan_enq_v);
    end else pass_count++;
    @(negedge CLK);
    total_count++;
    if (err_count !== 8'd0) $display("FAIL edge_err: got %0d required 0", err_count);
    else pass_count++;
  endtask

  task automatic test_backpressure();
    int e0, r0;
    bit bad = 1'b0;
    do_reset();
    e0 = ena_count;
    r0 = req_count;
    toBscan_enq__RDY = 1'b0;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h4000_0100;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b0;
    @(negedge CLK);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h5566_7788;
    @(negedge CLK);
    bus_rsp_valid = 1'b0;
    // Offer another header while stalled; it must not be taken
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h4000_0200;
    for (int i = 0; i < 50; i++) begin
      if (fromBscan_enq__RDY !== 1'b0 || toBscan_enq__ENA !== 1'b0) bad = 1'b1;
      @(negedge CLK);
    end
    total_count++;
    if (bad) $display("FAIL stall_hold: got rdy/ena activity during stall required none");
    else pass_count++;
    fromBscan_enq__ENA = 1'b0;
    toBscan_enq__RDY = 1'b1;
    #1;
    total_count++;
    if (toBscan_enq__ENA !== 1'b1 || toBscan_enq_v !== 32'h5566_7788) begin
      $display("FAIL stall_release: got ena=%b data=%h required 1 55667788", toBscan_enq__ENA, toBscan_enq_v);
    end else pass_count++;
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    total_count++;
    if (ena_count - e0 != 1 || req_count - r0 != 1 || fromBscan_enq__RDY !== 1'b1) begin
      $display("FAIL stall_done: got enas=%0d reqs=%0d rdy=%b required 1 1 1",
               ena_count - e0, req_count - r0, fromBscan_enq__RDY);
    end else pass_count++;
  endtask

  task automatic test_reserved();
    int r0 = req_count;
    // NOP leaves everything untouched
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h0000_0010;
    @(negedge CLK);
    fromBscan_enq_v = 32'hC000_0000;
    total_count++;
    if (err_count !== 8'd0 || bus_req_valid !== 1'b0 || fromBscan_enq__RDY !== 1'b1) begin
      $display("FAIL nop: got err=%0d valid=%b rdy=%b required 0 0 1", err_count, bus_req_valid, fromBscan_enq__RDY);
    end else pass_count++;
    @(negedge CLK);
    total_count++;
    if (err_count !== 8'd1) $display("FAIL rsvd_one: got %0d required 1", err_count);
    else pass_count++;
    repeat (254) @(negedge CLK);
    total_count++;
    if (err_count !== 8'd255) $display("FAIL rsvd_255: got %0d required 255", err_count);
    else pass_count++;
    repeat (45) @(negedge CLK);
    fromBscan_enq__ENA = 1'b0;
    @(negedge CLK);
    total_count++;
    if (err_count !== 8'd255 || req_count != r0) begin
      $display("FAIL rsvd_sat: got err=%0d reqs=%0d required 255 0", err_count, req_count - r0);
    end else pass_count++;
  endtask

  task automatic test_reset_mid();
    int e0, r0;
    do_reset();
    e0 = ena_count;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b1;
    fromBscan_enq_v = 32'h4000_0300;
    @(negedge CLK);
    fromBscan_enq__ENA = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    total_count++;
    if ({fromBscan_enq__RDY, toBscan_enq__ENA, bus_req_valid} !== 3'b000 || err_count !== 8'd0) begin
      $display("FAIL mid_reset: got rdy/ena/valid=%b err=%0d required 000 0",
               {fromBscan_enq__RDY, toBscan_enq__ENA, bus_req_valid}, err_count);
    end else pass_count++;
    @(negedge CLK);
    RST = 1'b0;
    r0 = req_count;
    @(negedge CLK);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h7777_0000;
    @(negedge CLK);
    bus_rsp_valid = 1'b0;
    repeat (5) @(negedge CLK);
    total_count++;
    if (ena_count != e0 || req_count != r0 || fromBscan_enq__RDY !== 1'b1 || err_count !== 8'd0) begin
      $display("FAIL late_rsp: got enas=%0d reqs=%0d rdy=%b err=%0d required 0 0 1 0",
               ena_count - e0, req_count - r0, fromBscan_enq__RDY, err_count);
    end else pass_count++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
